// File: rtl/barrel_normalizer.sv
// Iterative normalizer: shifts a word one bit per clock until its leading set bit
// reaches the MSB (left) or LSB (right), reporting the shift count that undoes it.
module barrel_normalizer #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned NW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] In,
  input  logic             Lr,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Out,
  output logic [NW-1:0]    n,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic [WIDTH-1:0] out_d;
  logic [NW-1:0]    n_d;
  logic             zero_d;
  logic             target_c;

  // Bit that must end up set for the word to count as normalized.
  assign target_c = lr_q ? work_q[WIDTH-1] : work_q[0];

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    lr_d    = lr_q;
    out_d   = Out;
    n_d     = n;
    zero_d  = zero;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (In == '0) begin
            out_d   = '0;
            n_d     = '0;
            zero_d  = 1'b1;
            state_d = DONE;
          end else begin
            work_d  = In;
            lr_d    = Lr;
            cnt_d   = '0;
            zero_d  = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (target_c) begin
          out_d   = work_q;
          n_d     = cnt_q;
          state_d = DONE;
        end else begin
          work_d = lr_q ? (work_q << 1) : (work_q >> 1);
          cnt_d  = cnt_q + NW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered status flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      lr_q    <= 1'b0;
      Out     <= '0;
      n       <= '0;
      zero    <= 1'b0;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      lr_q    <= lr_d;
      Out     <= out_d;
      n       <= n_d;
      zero    <= zero_d;
      ready   <= (state_d == IDLE);
      busy    <= (state_d == SHIFT);
      done    <= (state_d == DONE);
    end
  end

endmodule

// File: doc/barrel_normalizer.md
# barrel_normalizer

Iterative normalizer: the inverse of the 8-bit barrel shifter. Given a data word and a direction, it shifts the word one bit per clock until the leading set bit reaches the MSB (left) or LSB (right). It returns the normalized word and the shift count `n` that recovers it. Used ahead of the barrel shifter to extract alignment amounts. Applying the barrel shifter to `Out` with count `n` in the opposite direction reproduces the original `In`.

## Interface
- `WIDTH`, 8, data width; power of two, ≥ 2.
- `NW`, $clog2(WIDTH), width of the shift-count output (derived; do not override).
---
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when `ready`=1.
- `In`  in  WIDTH  word to normalize; captured with `start`.
- `Lr`  in  1  direction; 1 = normalize toward MSB (left), 0 = toward LSB (right); captured with `start`.
- `ready`  out  1  high in IDLE only.
- `busy`  out  1  high in SHIFT only.
- `done`  out  1  one-cycle pulse, high in DONE only.
- `Out`  out  WIDTH  normalized word; held from DONE until the next accepted `start`.
- `n`  out  NW  number of single-bit shifts applied; held like `Out`.
- `zero`  out  1  `In` was all zeros; held like `Out`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **IDLE**: `ready`=1.
  - `start`=1 and `In`≠0: latch `In` into the working register, latch `Lr`, clear the counter, clear `zero`, go to SHIFT.
  - `start`=1 and `In`=0: `Out`←0, `n`←0, `zero`←1, go directly to DONE.
- **SHIFT**: test the target bit each cycle (bit WIDTH-1 if `Lr`=1, bit 0 if `Lr`=0).
  - Target bit set: copy the working register to `Out` and the count to `n`, go to DONE.
  - Target bit clear: shift the register one place toward the target (zero fill), increment the count, stay in SHIFT.
  - Count never exceeds WIDTH-1, since a nonzero word always terminates.
- **DONE**: `done`=1 for exactly one cycle, then go to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; no queuing.
- `In` and `Lr` may change freely after capture without effect.
- Result invariants:
  - Left: `Out` = `In` << `n`, `Out`[WIDTH-1]=1, `Out` >> `n` = `In`.
  - Right: `Out` = `In` >> `n`, `Out`[0]=1, `Out` << `n` = `In`.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `Out`=0, `n`=0, `zero`=0, working register and counter 0.
- Latency: let `start` be sampled at edge E0 and let k be the required shift count.
  - Nonzero `In`: SHIFT occupies cycles E0..E(k+1). DONE, with outputs valid, follows edge E(k+1), i.e. k+2 cycles after the start cycle.
  - Zero `In`: DONE follows E0 directly, 1 cycle.
  - Worst case is WIDTH+1 cycles (k = WIDTH-1).
- Throughput: the next `start` is accepted in the cycle after DONE, at the earliest.
- `Out`, `n` and `zero` update on the edge entering DONE and are stable until an accepted `start`. A zero-input start updates them on the edge entering DONE.
- `rst` asserted in any state, including mid-SHIFT, returns every output to its reset value at that edge. The in-flight operation is discarded and no `done` is issued.
- `rst` and `start` high in the same cycle: reset wins and `start` is lost.

## Test plan
- Left normalize: `In`=0x10, `Lr`=1, `start` for 1 cycle → `busy` for 4 cycles, then `done` pulse with `Out`=0x80, `n`=3, `zero`=0; `ready` returns the next cycle.
- Right extremes: `In`=0x80, `Lr`=0 → `Out`=0x01, `n`=7, `done` 9 cycles after the start cycle. `In`=0x01, `Lr`=0 → `Out`=0x01, `n`=0, `done` 2 cycles after.
- Zero input: `In`=0x00, either `Lr` → `done` in the next cycle, `Out`=0x00, `n`=0, `zero`=1, `busy` never asserted.
- Start while busy: start `In`=0x01, `Lr`=1, then pulse `start` with `In`=0xFF during SHIFT and during DONE → single result `Out`=0x80, `n`=7; exactly one `done` pulse.
- Reset mid-operation: start `In`=0x02, `Lr`=1, assert `rst` on the 3rd SHIFT cycle → all outputs at reset values, no `done`. A subsequent start with `In`=0x40, `Lr`=1 → `Out`=0x80, `n`=1.
- Round trip: all 255 nonzero `In` values × both `Lr` values → the invariants hold, and latency equals `n`+2 for every case.
